uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_PER_HALF_BIT, default 1406, clocks per half bit period (>=2); one bit period = 2*CLK_PER_HALF_BIT clocks.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-005 SHALL have ports in this order:
  clk  input  1  sole clock, rising edge.
  rst  input  1  asynchronous, active-high reset.
  rxd  input  1  asynchronous serial line, idle high.
  rdata  output  DATA_BITS  received word, LSB = first data bit.
  rvalid  output  1  rdata/ferr/perr valid.
  rready  input  1  consumer accepts word.
  ferr  output  1  framing error for the held word.
  perr  output  1  parity error for the held word (0 when PARITY=0).
  overrun  output  1  one-cycle pulse: a completed frame was dropped.
  busy  output  1  high in every state except IDLE.

Function
REQ-006 SHALL pass rxd through a 2-flop synchroniser reset to 1; all decisions use the synchronised value rxs.
REQ-007 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-008 IDLE: rxs==0 -> START, bit counter cleared.
REQ-009 START: rxs==1 before the counter reaches CLK_PER_HALF_BIT-1 -> IDLE (glitch, no output); rxs==0 at count CLK_PER_HALF_BIT-1 -> DATA, counter cleared (mid-start-bit alignment).
REQ-010 DATA: sample rxs when counter == 2*CLK_PER_HALF_BIT-1, shift LSB-first into shift register; after DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
REQ-011 PARITY: one sample at same spacing; perr_next = (XOR of data bits XOR sampled bit) != (PARITY==2).
REQ-012 STOP: STOP_BITS samples at same spacing; any stop sample == 0 sets ferr_next.
REQ-013 At the last stop sample: ferr_next==0 -> IDLE; ferr_next==1 -> WAIT_HIGH.
REQ-014 WAIT_HIGH: remain until rxs==1, then IDLE (a break never re-triggers a start).
REQ-015 Delivery, in the cycle after the last stop sample: if rvalid==0 or (rvalid & rready) in that cycle, load rdata, ferr, perr and set rvalid=1; otherwise keep the held word and pulse overrun for exactly one cycle.
REQ-016 rvalid SHALL stay high until the cycle rvalid & rready is sampled, then clear on the next edge unless a new load coincides (REQ-015).
REQ-017 rdata, ferr and perr SHALL remain stable while rvalid==1.
REQ-018 Receive latency: rvalid rises 1 clock after the final stop-bit sample, plus 2 clocks of synchroniser delay relative to the line.
REQ-019 Counter SHALL be wide enough for 2*CLK_PER_HALF_BIT-1 ($clog2) and SHALL clear on every state change.

Reset
REQ-020 On rst: state=IDLE, synchroniser=1, counters=0, rdata=0, rvalid=0, ferr=0, perr=0, overrun=0, busy=0.
REQ-021 Reset mid-frame SHALL abort the frame with no output; after release, reception begins at the next falling edge.

Structure
REQ-022 Package uart_pkg SHALL hold the state enum and the PARITY_NONE/EVEN/ODD constants.
REQ-023 Sub-module uart_baud_ctr (counter with clear, half-point and full-point strobes) SHALL be instantiated once.
REQ-024 Illegal parameter values SHALL be rejected at elaboration time.

Verification (CLK_PER_HALF_BIT=4, bit = 8 clocks)
REQ-025 8N1 frame 0xA5, rready=1 -> one rvalid pulse, rdata=0xA5, ferr=0, perr=0.
REQ-026 8E1 frame 0x07 with parity bit 0 -> rdata=0x07, perr=1; same frame with parity bit 1 -> perr=0.
REQ-027 rxd low for 2 clocks, then high -> no rvalid, returns to IDLE, busy low again within 6 clocks.
REQ-028 8N1 0x3C with stop bit 0, line held low for 40 clocks -> rdata=0x3C, ferr=1; no second frame until rxd returns high.
REQ-029 rready=0, frames 0x11 then 0x22 -> rdata stays 0x11, overrun pulses once; after rready, rvalid clears.
REQ-030 7O2 frame 0x55, rst asserted during bit 3, then a clean frame 0x2A -> only 0x2A delivered, perr=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receiver slice.
//   - uart_state_e : receiver FSM state encoding
//   - PARITY_*     : values accepted by the PARITY parameter
//   - parity_bit   : parity bit a transmitter would append to a word
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Parity bit that makes the total number of ones even (odd_mode=0)
  // or odd (odd_mode=1) across data and parity.
  function automatic logic parity_bit(input logic data_xor, input logic odd_mode);
    return data_xor ^ odd_mode;
  endfunction

endpackage

// File: rtl/uart_baud_ctr.sv
// uart_baud_ctr
//   Free-running bit-timing counter for the UART receiver.
//   Counts 0 .. 2*CLK_PER_HALF_BIT-1 and wraps, so one wrap equals one
//   bit period. A synchronous clear restarts the count at zero.
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   clr   : restart count at zero on the next edge
//   half  : count == CLK_PER_HALF_BIT-1   (middle of the start bit)
//   full  : count == 2*CLK_PER_HALF_BIT-1 (one bit period elapsed)
module uart_baud_ctr #(
  parameter int CLK_PER_HALF_BIT = 1406
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic half,
  output logic full
);

  localparam int CW = $clog2(2 * CLK_PER_HALF_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(2 * CLK_PER_HALF_BIT - 1);

  logic [CW-1:0] cnt;

  assign half = (cnt == HALF_CNT);
  assign full = (cnt == FULL_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || full) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg
//   Configurable UART receiver (data bits, parity mode, stop bits) with a
//   one-word holding register and valid/ready handshake.
// Ports
//   clk     : sole clock, rising edge
//   rst     : asynchronous active-high reset
//   rxd     : asynchronous serial line, idle high
//   rdata   : received word, LSB = first data bit
//   rvalid  : rdata/ferr/perr hold a word not yet accepted
//   rready  : consumer accepts the held word
//   ferr    : framing error for the held word (a stop sample was 0)
//   perr    : parity error for the held word (always 0 without parity)
//   overrun : one-cycle pulse when a completed frame was dropped
//   busy    : receiver is not idle
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | line high, waiting for a falling edge
// START      | qualifying the start bit up to its middle
// DATA       | sampling DATA_BITS data bits, one per bit period
// PARITY     | sampling the parity bit
// STOP       | sampling STOP_BITS stop bits
// WAIT_HIGH  | framing error seen, waiting for the line to go high
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 1406,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rvalid,
  input  logic                 rready,
  output logic                 ferr,
  output logic                 perr,
  output logic                 overrun,
  output logic                 busy
);

  if (CLK_PER_HALF_BIT < 2) begin : g_bad_half_bit
    $error("uart_rx_cfg: CLK_PER_HALF_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_parity
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam logic       HAS_PARITY = (PARITY != PARITY_NONE);
  localparam logic       ODD_MODE   = (PARITY == PARITY_ODD);
  localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);

  // Two-flop synchroniser; resets to the idle line level so that a reset
  // release never looks like a start bit.
  logic rx_meta;
  logic rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  uart_state_e          state;
  uart_state_e          state_nxt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_acc;
  logic                 perr_acc;
  logic                 deliver_q;
  logic                 cnt_clr;
  logic                 half;
  logic                 full;
  logic                 stop_last;

  uart_baud_ctr #(
    .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .half(half),
    .full(full)
  );

  assign stop_last = (state == ST_STOP) && full && (bit_cnt == LAST_STOP);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (!rxs) state_nxt = ST_START;
      end
      ST_START: begin
        // Any high sample before mid-start is treated as a glitch.
        if (rxs)       state_nxt = ST_IDLE;
        else if (half) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (full && bit_cnt == LAST_DATA) state_nxt = HAS_PARITY ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (full) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        // The final stop sample is folded in here since ferr_acc only
        // sees it on the following edge.
        if (stop_last) state_nxt = (ferr_acc || !rxs) ? ST_WAIT_HIGH : ST_IDLE;
      end
      ST_WAIT_HIGH: begin
        if (rxs) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bit timing restarts on every state change; IDLE and WAIT_HIGH hold it
  // at zero so entry into START always begins a fresh half-bit count.
  assign cnt_clr = (state_nxt != state) || (state == ST_IDLE) || (state == ST_WAIT_HIGH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ferr_acc  <= 1'b0;
      perr_acc  <= 1'b0;
      deliver_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      deliver_q <= stop_last;

      if (state_nxt != state) begin
        bit_cnt <= '0;
      end else if (full) begin
        bit_cnt <= bit_cnt + 4'd1;
      end

      if (state == ST_START) begin
        ferr_acc <= 1'b0;
        perr_acc <= 1'b0;
      end

      if (state == ST_DATA && full) begin
        shreg <= {rxs, shreg[DATA_BITS-1:1]};
      end

      if (state == ST_PARITY && full) begin
        perr_acc <= (rxs != parity_bit(^shreg, ODD_MODE));
      end

      if (state == ST_STOP && full && !rxs) begin
        ferr_acc <= 1'b1;
      end
    end
  end

  // Holding register. shreg, ferr_acc and perr_acc are still intact in the
  // deliver cycle because the next frame cannot reach START that soon.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata   <= '0;
      rvalid  <= 1'b0;
      ferr    <= 1'b0;
      perr    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= deliver_q && rvalid && !rready;
      if (deliver_q && (!rvalid || rready)) begin
        rvalid <= 1'b1;
        rdata  <= shreg;
        ferr   <= ferr_acc;
        perr   <= perr_acc;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) at four clocks
// per half bit. A frame-level model predicts, from the bits put on the
// line, which word each instance must present and on which cycle; a
// compare process checks every output against it on each falling edge.
module tb_uart_rx_cfg;

  localparam int H   = 4;
  localparam int BIT = 2 * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rxd_b = 3'b111;
  logic [2:0] rready_b = 3'b111;
  logic [7:0] rdata0, rdata1;
  logic [6:0] rdata2;
  logic [2:0] rvalid_b, ferr_b, perr_b, ovr_b, busy_b;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLK_PER_HALF_BIT(H), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .rxd(rxd_b[0]), .rdata(rdata0), .rvalid(rvalid_b[0]),
    .rready(rready_b[0]), .ferr(ferr_b[0]), .perr(perr_b[0]), .overrun(ovr_b[0]), .busy(busy_b[0]));
  uart_rx_cfg #(.CLK_PER_HALF_BIT(H), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .rxd(rxd_b[1]), .rdata(rdata1), .rvalid(rvalid_b[1]),
    .rready(rready_b[1]), .ferr(ferr_b[1]), .perr(perr_b[1]), .overrun(ovr_b[1]), .busy(busy_b[1]));
  uart_rx_cfg #(.CLK_PER_HALF_BIT(H), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst(rst), .rxd(rxd_b[2]), .rdata(rdata2), .rvalid(rvalid_b[2]),
    .rready(rready_b[2]), .ferr(ferr_b[2]), .perr(perr_b[2]), .overrun(ovr_b[2]), .busy(busy_b[2]));

  function automatic int db_of(input int i);  return (i == 2) ? 7 : 8; endfunction
  function automatic int par_of(input int i); return i; endfunction
  function automatic int sb_of(input int i);  return (i == 2) ? 2 : 1; endfunction

  function automatic logic [8:0] rdata_of(input int i);
    case (i)
      0:       return {1'b0, rdata0};
      1:       return {1'b0, rdata1};
      default: return {2'b00, rdata2};
    endcase
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cycle %0d: got 0x%0h expected 0x%0h", nm, i, cyc, act, exp);
    end
  endtask

  // Frame announcements from the stimulus side (only stimulus writes these).
  int         s_seq  [3] = '{0, 0, 0};
  int         s_time [3];
  logic [8:0] s_data [3];
  bit         s_ferr [3];
  bit         s_perr [3];

  // Model state (only the model process writes these).
  int         seen   [3] = '{0, 0, 0};
  bit         p_valid[3] = '{0, 0, 0};
  int         p_time [3];
  logic [8:0] p_data [3];
  bit         p_ferr [3];
  bit         p_perr [3];
  bit         m_valid[3] = '{0, 0, 0};
  logic [8:0] m_data [3] = '{9'd0, 9'd0, 9'd0};
  bit         m_ferr [3] = '{0, 0, 0};
  bit         m_perr [3] = '{0, 0, 0};
  bit         m_ovr  [3] = '{0, 0, 0};
  int         ovr_cnt[3] = '{0, 0, 0};
  bit         rnd_on = 0;

  task automatic model_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          seen[i] = s_seq[i];
          p_valid[i] = 0;
          m_valid[i] = 0; m_data[i] = '0; m_ferr[i] = 0; m_perr[i] = 0; m_ovr[i] = 0;
          chk("rst_rvalid", i, 32'(rvalid_b[i]), 32'd0);
          chk("rst_rdata", i, 32'(rdata_of(i)), 32'd0);
          chk("rst_flags", i, 32'({ferr_b[i], perr_b[i], ovr_b[i]}), 32'd0);
          chk("rst_busy", i, 32'(busy_b[i]), 32'd0);
        end else begin
          if (s_seq[i] != seen[i]) begin
            seen[i] = s_seq[i];
            p_valid[i] = 1; p_time[i] = s_time[i];
            p_data[i] = s_data[i]; p_ferr[i] = s_ferr[i]; p_perr[i] = s_perr[i];
          end
          chk("rvalid", i, 32'(rvalid_b[i]), 32'(m_valid[i]));
          chk("rdata", i, 32'(rdata_of(i)), 32'(m_data[i]));
          chk("ferr", i, 32'(ferr_b[i]), 32'(m_ferr[i]));
          chk("perr", i, 32'(perr_b[i]), 32'(m_perr[i]));
          chk("overrun", i, 32'(ovr_b[i]), 32'(m_ovr[i]));
          if (ovr_b[i]) ovr_cnt[i]++;
          m_ovr[i] = 0;
          if (p_valid[i] && p_time[i] == cyc) begin
            p_valid[i] = 0;
            if (!m_valid[i] || rready_b[i]) begin
              m_valid[i] = 1; m_data[i] = p_data[i]; m_ferr[i] = p_ferr[i]; m_perr[i] = p_perr[i];
            end else begin
              m_ovr[i] = 1;
            end
          end else if (m_valid[i] && rready_b[i]) begin
            m_valid[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drives one frame on line i. Leaves the line at the last bit value.
  // abort_bits>0: stop half way into frame bit number abort_bits.
  task automatic send_frame(input int i, input logic [8:0] d, input bit pflip,
                            input logic [1:0] stops, input int abort_bits);
    int         db = db_of(i);
    int         pm = par_of(i);
    int         sb = sb_of(i);
    int         nb;
    logic [8:0] dm;
    logic       pbit;
    bit         fe;
    logic       fbits [0:12];
    dm   = d & ((9'h1 << db) - 9'h1);
    pbit = (^dm) ^ (pm == 2);
    pbit = pbit ^ pflip;
    fe   = 0;
    nb   = 0;
    fbits[nb++] = 1'b0;
    for (int k = 0; k < db; k++) fbits[nb++] = dm[k];
    if (pm != 0) fbits[nb++] = pbit;
    for (int k = 0; k < sb; k++) begin
      fbits[nb++] = stops[k];
      if (!stops[k]) fe = 1;
    end
    // rxs falls 2 clocks after the line; sample of frame bit b happens
    // 3H + 2H*(b-1) clocks later; the word appears 2 clocks after the last one.
    s_time[i] = cyc + 2 + 3 * H + BIT * (nb - 2) + 1;
    s_data[i] = dm;
    s_ferr[i] = fe;
    s_perr[i] = (pm != 0) && pflip;
    s_seq[i]++;
    for (int k = 0; k < nb; k++) begin
      rxd_b[i] = fbits[k];
      if (abort_bits > 0 && k == abort_bits) begin
        wait_cyc(H);
        return;
      end
      wait_cyc(BIT);
    end
  endtask

  task automatic wait_rv(input int i, input int bound, output int t);
    t = -1;
    for (int k = 0; k <= bound; k++) begin
      if (rvalid_b[i]) begin
        t = cyc;
        break;
      end
      wait_cyc(1);
    end
    chk("rvalid_seen", i, 32'(t >= 0), 32'd1);
  endtask

  task automatic rand_tx(input int i);
    logic [1:0] st;
    for (int n = 0; n < 10; n++) begin
      st = 2'b11;
      if ($urandom_range(0, 5) == 0) st[$urandom_range(0, sb_of(i) - 1)] = 1'b0;
      send_frame(i, 9'($urandom), ($urandom_range(0, 3) == 0), st, 0);
      rxd_b[i] = 1'b1;
      wait_cyc($urandom_range(2, 30));
    end
  endtask

  task automatic rready_drv();
    forever begin
      @(posedge clk);
      #2;
      if (rnd_on) rready_b = 3'($urandom);
    end
  endtask

  task automatic watchdog();
    #600000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  endtask

  task automatic main_seq();
    int t0, tr, oc;
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(5);

    // 8N1 0xA5, ready held high: single-cycle rvalid 80 clocks after start
    t0 = cyc;
    send_frame(0, 9'h0A5, 0, 2'b11, 0);
    rxd_b[0] = 1'b1;
    wait_rv(0, 20, tr);
    chk("lat_8n1", 0, 32'(tr - t0), 32'd80);
    chk("a5_data", 0, 32'(rdata0), 32'h0A5);
    chk("a5_flags", 0, 32'({ferr_b[0], perr_b[0]}), 32'd0);
    wait_cyc(10);

    // 8E1 0x07: parity bit 0 is wrong (three ones), then parity bit 1
    t0 = cyc;
    send_frame(1, 9'h007, 1, 2'b11, 0);
    rxd_b[1] = 1'b1;
    wait_rv(1, 20, tr);
    chk("lat_8e1", 1, 32'(tr - t0), 32'd88);
    chk("07_data", 1, 32'(rdata1), 32'h007);
    chk("07_perr_bad", 1, 32'(perr_b[1]), 32'd1);
    wait_cyc(10);
    send_frame(1, 9'h007, 0, 2'b11, 0);
    rxd_b[1] = 1'b1;
    wait_rv(1, 20, tr);
    chk("07_perr_good", 1, 32'(perr_b[1]), 32'd0);
    wait_cyc(10);

    // Two-clock glitch on the 8N1 line
    rxd_b[0] = 1'b0;
    wait_cyc(2);
    rxd_b[0] = 1'b1;
    wait_cyc(2);
    chk("glitch_busy_hi", 0, 32'(busy_b[0]), 32'd1);
    wait_cyc(4);
    chk("glitch_busy_lo", 0, 32'(busy_b[0]), 32'd0);
    wait_cyc(100);

    // 0x3C with a zero stop bit followed by a 40-clock break
    send_frame(0, 9'h03C, 0, 2'b00, 0);
    wait_rv(0, 20, tr);
    chk("3c_data", 0, 32'(rdata0), 32'h03C);
    chk("3c_ferr", 0, 32'(ferr_b[0]), 32'd1);
    wait_cyc(40);
    chk("break_busy", 0, 32'(busy_b[0]), 32'd1);
    rxd_b[0] = 1'b1;
    wait_cyc(6);
    chk("break_end_busy", 0, 32'(busy_b[0]), 32'd0);
    wait_cyc(10);

    // Consumer stalled: second word is dropped with one overrun pulse
    rready_b[0] = 1'b0;
    oc = ovr_cnt[0];
    send_frame(0, 9'h011, 0, 2'b11, 0);
    rxd_b[0] = 1'b1;
    wait_cyc(4);
    send_frame(0, 9'h022, 0, 2'b11, 0);
    rxd_b[0] = 1'b1;
    wait_cyc(4);
    chk("ovr_count", 0, 32'(ovr_cnt[0] - oc), 32'd1);
    chk("held_data", 0, 32'(rdata0), 32'h011);
    chk("held_valid", 0, 32'(rvalid_b[0]), 32'd1);
    rready_b[0] = 1'b1;
    wait_cyc(1);
    chk("drain_valid", 0, 32'(rvalid_b[0]), 32'd0);
    wait_cyc(10);

    // 7O2 0x55 aborted by reset during data bit 3, then clean 0x2A
    send_frame(2, 9'h055, 0, 2'b11, 4);
    rxd_b[2] = 1'b1;
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(4);
    chk("abort_no_valid", 2, 32'(rvalid_b[2]), 32'd0);
    t0 = cyc;
    send_frame(2, 9'h02A, 0, 2'b11, 0);
    rxd_b[2] = 1'b1;
    wait_rv(2, 20, tr);
    chk("lat_7o2", 2, 32'(tr - t0), 32'd88);
    chk("2a_data", 2, 32'(rdata2), 32'h02A);
    chk("2a_flags", 2, 32'({ferr_b[2], perr_b[2]}), 32'd0);
    wait_cyc(10);

    // Randomised traffic on all three lines with a randomly stalling consumer
    rnd_on = 1;
    fork
      rand_tx(0);
      rand_tx(1);
      rand_tx(2);
    join
    wait_cyc(20);
    rnd_on = 0;
    rready_b = 3'b111;
    wait_cyc(40);
    for (int i = 0; i < 3; i++) chk("drained", i, 32'(p_valid[i]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  initial begin
    fork
      model_loop();
      rready_drv();
      watchdog();
      main_seq();
    join
  end

endmodule
